light_track_pwm: RTL and testbench

LIGHT_TRACK_PWM -- requirements
Module: light_track_pwm

---
 rtl/light_pkg.sv | 30 +++
 rtl/light_chan.sv | 106 ++++++++++
 rtl/light_track_pwm.sv | 96 +++++++++
 tb/tb_light_track_pwm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// light_pkg: shared definitions for the light tracking PWM controller.
//   chan_state_t : per-channel state encoding (OFF, START, RUN)
//   err_width()  : width of the signed target-current error for W-bit inputs
//   clamp_val()  : saturate an integer into [lo, hi]
package light_pkg;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_START = 2'd1,
    CH_RUN   = 2'd2
  } chan_state_t;

  // One extra bit holds the sign of target - current for unsigned W-bit operands.
  function automatic int err_width(input int w);
    return w + 1;
  endfunction

  // Arithmetic is done in int so that shadow+STEP / shadow-STEP can leave the
  // W-bit range without wrapping before it is saturated.
  function automatic int clamp_val(input int v, input int lo, input int hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/light_chan.sv
// light_chan: one light channel -- state machine, shadow/active duty and the
// PWM compare.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              control tick from the top level (inputs sampled here)
//   wrap              high while the shared PWM counter is at its last count
//   pwm_cnt [W]       shared PWM counter value
//   en, mode          channel enable (level), 0 = track, 1 = direct duty
//   current, target   measured brightness and setpoint, unsigned
//   pwm               registered PWM output
//   duty [W]          active (applied) duty
//   at_target         error inside the deadband at the last tick while in RUN
module light_chan
  import light_pkg::*;
#(
  parameter int W        = 8,
  parameter int STEP     = 1,
  parameter int DEADBAND = 2,
  parameter int MIN_DUTY = 1,
  parameter int MAX_DUTY = 254
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         wrap,
  input  logic [W-1:0] pwm_cnt,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] current,
  input  logic [W-1:0] target,
  output logic         pwm,
  output logic [W-1:0] duty,
  output logic         at_target
);

  localparam int EW = err_width(W);
  localparam logic signed [EW-1:0] DB_POS = EW'(DEADBAND);
  localparam logic signed [EW-1:0] DB_NEG = -DB_POS;

  chan_state_t          state;
  logic [W-1:0]         shadow;
  logic signed [EW-1:0] err;
  logic [W-1:0]         up_val;
  logic [W-1:0]         dn_val;
  logic [W-1:0]         direct_val;
  logic                 direct_hit;

  assign err = $signed({1'b0, target}) - $signed({1'b0, current});

  // Candidate next shadow values, already saturated to [MIN_DUTY, MAX_DUTY].
  always_comb begin
    up_val     = W'(clamp_val(int'(shadow) + STEP, MIN_DUTY, MAX_DUTY));
    dn_val     = W'(clamp_val(int'(shadow) - STEP, MIN_DUTY, MAX_DUTY));
    direct_val = W'(clamp_val(int'(target), MIN_DUTY, MAX_DUTY));
    direct_hit = (direct_val == target);
  end

  // Channel FSM. Dropping en clears both duty registers at once instead of
  // waiting for the PWM wrap, so the light goes dark on the next cycle.
  // Active duty only reloads at the wrap so a PWM period is never cut short.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state     <= CH_OFF;
      shadow    <= '0;
      duty      <= '0;
      pwm       <= 1'b0;
      at_target <= 1'b0;
    end else begin
      pwm <= (pwm_cnt < duty);
      if (wrap) begin
        duty <= shadow;
      end
      case (state)
        CH_OFF: begin
          state <= CH_START;
        end
        CH_START: begin
          if (tick) begin
            shadow <= W'(MIN_DUTY);
            state  <= CH_RUN;
          end
        end
        CH_RUN: begin
          if (tick) begin
            if (mode) begin
              shadow    <= direct_val;
              at_target <= direct_hit;
            end else if (err > DB_POS) begin
              shadow    <= up_val;
              at_target <= 1'b0;
            end else if (err < DB_NEG) begin
              shadow    <= dn_val;
              at_target <= 1'b0;
            end else begin
              at_target <= 1'b1;
            end
          end
        end
        default: begin
          state <= CH_OFF;
        end
      endcase
    end
  end

endmodule

// File: rtl/light_track_pwm.sv
// light_track_pwm: CH-channel brightness tracker driving PWM outputs.
// Holds the shared control-tick and PWM counters and one light_chan per channel.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en [CH]             per-channel enable
//   mode [CH]           per-channel mode, 0 = closed-loop track, 1 = direct duty
//   current [CH*W]      measured brightness, channel i at [i*W +: W]
//   target [CH*W]       setpoint, same packing
//   pwm [CH]            registered PWM outputs
//   duty [CH*W]         active duty per channel
//   at_target [CH]      channel on target at the last tick
//   tick                one-cycle pulse per control tick
module light_track_pwm
  import light_pkg::*;
#(
  parameter int CH       = 4,
  parameter int W        = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 1,
  parameter int DEADBAND = 2,
  parameter int MIN_DUTY = 1,
  parameter int MAX_DUTY = (1 << W) - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   mode,
  input  logic [CH*W-1:0] current,
  input  logic [CH*W-1:0] target,
  output logic [CH-1:0]   pwm,
  output logic [CH*W-1:0] duty,
  output logic [CH-1:0]   at_target,
  output logic            tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // The PWM counter stops one short of all-ones so a duty of 2^W-1 would be
  // fully on; the period is 2^W-1 cycles.
  localparam logic [W-1:0] PWM_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [TW-1:0] tick_cnt;
  logic [W-1:0]  pwm_cnt;
  logic          wrap;

  // tick is decoded from the counter; reset forces the counter to 0, so tick
  // is low in the cycle after reset and the first tick lands TICK_DIV cycles later.
  assign tick = (tick_cnt == TICK_LAST);
  assign wrap = (pwm_cnt == PWM_LAST);

  // Control tick divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Shared PWM period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (wrap) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    light_chan #(
      .W        (W),
      .STEP     (STEP),
      .DEADBAND (DEADBAND),
      .MIN_DUTY (MIN_DUTY),
      .MAX_DUTY (MAX_DUTY)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .wrap      (wrap),
      .pwm_cnt   (pwm_cnt),
      .en        (en[i]),
      .mode      (mode[i]),
      .current   (current[i*W +: W]),
      .target    (target[i*W +: W]),
      .pwm       (pwm[i]),
      .duty      (duty[i*W +: W]),
      .at_target (at_target[i])
    );
  end

endmodule

// File: tb/tb_light_track_pwm.sv
// tb_light_track_pwm: directed scoreboard bench for light_track_pwm with
// CH=2, W=8, TICK_DIV=4, STEP=1, DEADBAND=2, MIN_DUTY=1, MAX_DUTY=254.
// Timeline reference: cyc counts clock edges since reset release. Ticks are
// acted on at edges 4,8,12,...; the PWM counter wraps at edges 255,510,765,...
// where active duty takes the shadow value accumulated by the preceding ticks.
module tb_light_track_pwm;

  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] current;
  logic [CH*W-1:0] target;
  logic [CH-1:0]   pwm;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   at_target;
  logic            tick;

  typedef enum int {
    SEL_DUTY0, SEL_DUTY1, SEL_PWM0, SEL_PWM1,
    SEL_AT0, SEL_AT1, SEL_TICK, SEL_HI0, SEL_HI1
  } sel_t;

  typedef struct {
    string name;
    sel_t  sel;
    int    expv;
  } exp_t;

  exp_t sb[$];
  exp_t cur_e;
  int   act_v;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hi0   = 0;
  int   hi1   = 0;
  bit   cnt_en = 1'b0;

  light_track_pwm #(
    .CH       (CH),
    .W        (W),
    .TICK_DIV (4),
    .STEP     (1),
    .DEADBAND (2),
    .MIN_DUTY (1),
    .MAX_DUTY (254)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .current   (current),
    .target    (target),
    .pwm       (pwm),
    .duty      (duty),
    .at_target (at_target),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release, used to place stimulus and checks.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Counts PWM-high cycles over one measurement window.
  always @(negedge clk) begin
    if (cnt_en) begin
      hi0 = hi0 + int'(pwm[0]);
      hi1 = hi1 + int'(pwm[1]);
    end
  end

  // Monitor: drains the scoreboard and compares against the DUT outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur_e = sb.pop_front();
      case (cur_e.sel)
        SEL_DUTY0: act_v = int'(duty[W-1:0]);
        SEL_DUTY1: act_v = int'(duty[2*W-1:W]);
        SEL_PWM0:  act_v = int'(pwm[0]);
        SEL_PWM1:  act_v = int'(pwm[1]);
        SEL_AT0:   act_v = int'(at_target[0]);
        SEL_AT1:   act_v = int'(at_target[1]);
        SEL_TICK:  act_v = int'(tick);
        SEL_HI0:   act_v = hi0;
        SEL_HI1:   act_v = hi1;
        default:   act_v = -1;
      endcase
      total = total + 1;
      if (act_v != cur_e.expv) begin
        bad = bad + 1;
        $display("[TB] FAIL %s: got %0d, expected %0d (cyc=%0d)", cur_e.name, act_v, cur_e.expv, cyc);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] en_v, input logic [1:0] mode_v,
                               input int t0, input int c0, input int t1, input int c1);
    en      = en_v;
    mode    = mode_v;
    target  = {W'(t1), W'(t0)};
    current = {W'(c1), W'(c0)};
  endtask

  task automatic checkOutput(input string name, input sel_t sel, input int expv);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.expv = expv;
    sb.push_back(e);
  endtask

  // Advances to 1 time unit after the edge that brings cyc to k.
  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc < k) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 6000) begin
        $display("[TB] FAIL wait_cyc: cyc=%0d, expected %0d", cyc, k);
        $fatal(1, "[TB] edge counter stuck");
      end
    end
    if (cyc != k) begin
      $display("[TB] FAIL wait_cyc: cyc=%0d, expected %0d", cyc, k);
      $fatal(1, "[TB] overshot target edge");
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_duty0", SEL_DUTY0, 0);
    checkOutput("rst_duty1", SEL_DUTY1, 0);
    checkOutput("rst_pwm0",  SEL_PWM0,  0);
    checkOutput("rst_at0",   SEL_AT0,   0);
    checkOutput("rst_tick",  SEL_TICK,  0);

    // ch0 tracks up (target 100, current 0); ch1 direct with target 0.
    rst = 1'b0;
    applyStimulus(2'b11, 2'b10, 100, 0, 0, 0);
    wait_cyc(1);   checkOutput("start_duty0", SEL_DUTY0, 0);
                   checkOutput("tick_c1", SEL_TICK, 0);
    wait_cyc(2);   checkOutput("tick_c2", SEL_TICK, 0);
    wait_cyc(3);   checkOutput("tick_c3", SEL_TICK, 1);
    wait_cyc(4);   checkOutput("tick_c4", SEL_TICK, 0);
    wait_cyc(8);   checkOutput("direct0_at1", SEL_AT1, 0);
    wait_cyc(254); checkOutput("prewrap_duty0", SEL_DUTY0, 0);
                   checkOutput("prewrap_duty1", SEL_DUTY1, 0);
    wait_cyc(255); checkOutput("ramp1_duty0", SEL_DUTY0, 63);
                   checkOutput("ramp1_at0", SEL_AT0, 0);
                   checkOutput("direct0_duty1", SEL_DUTY1, 1);
    applyStimulus(2'b11, 2'b10, 100, 0, 255, 0);
    wait_cyc(256); checkOutput("direct255_at1", SEL_AT1, 0);
    wait_cyc(510); checkOutput("ramp2_duty0", SEL_DUTY0, 127);
                   checkOutput("direct255_duty1", SEL_DUTY1, 254);

    // ch0 inside deadband (err=-2); ch1 direct 128.
    applyStimulus(2'b11, 2'b10, 50, 52, 128, 0);
    wait_cyc(512); checkOutput("band_lo_at0", SEL_AT0, 1);
                   checkOutput("direct128_at1", SEL_AT1, 1);
                   checkOutput("hold_active_duty1", SEL_DUTY1, 254);
    wait_cyc(764); checkOutput("prewrap_duty1_b", SEL_DUTY1, 254);
    wait_cyc(765); checkOutput("band_duty0", SEL_DUTY0, 127);
                   checkOutput("band_at0", SEL_AT0, 1);
                   checkOutput("direct128_duty1", SEL_DUTY1, 128);
    wait_cyc(766); cnt_en = 1'b1;
    applyStimulus(2'b11, 2'b10, 50, 48, 128, 0);
    wait_cyc(768); checkOutput("band_hi_at0", SEL_AT0, 1);
    wait_cyc(1013);
    applyStimulus(2'b11, 2'b10, 50, 53, 128, 0);
    wait_cyc(1016); checkOutput("over_at0", SEL_AT0, 0);
                    checkOutput("over_prewrap_duty0", SEL_DUTY0, 127);
    wait_cyc(1020); checkOutput("over_duty0", SEL_DUTY0, 126);
                    checkOutput("keep_duty1", SEL_DUTY1, 128);

    // ch0 saturate upward; ch1 switches to track inside the deadband.
    applyStimulus(2'b11, 2'b00, 255, 0, 100, 100);
    wait_cyc(1021); cnt_en = 1'b0;
                    checkOutput("pwm_high_ch0", SEL_HI0, 127);
                    checkOutput("pwm_high_ch1", SEL_HI1, 128);
    wait_cyc(1024); checkOutput("bumpless_at1", SEL_AT1, 1);
                    checkOutput("up_at0", SEL_AT0, 0);
    wait_cyc(1275); checkOutput("up1_duty0", SEL_DUTY0, 188);
                    checkOutput("bumpless_duty1", SEL_DUTY1, 128);
    wait_cyc(1530); checkOutput("up2_duty0", SEL_DUTY0, 252);
    wait_cyc(1785); checkOutput("sat_hi_duty0", SEL_DUTY0, 254);
    wait_cyc(2040); checkOutput("sat_hi_hold_duty0", SEL_DUTY0, 254);

    // ch0 saturate downward.
    applyStimulus(2'b11, 2'b00, 0, 255, 100, 100);
    wait_cyc(2295); checkOutput("dn1_duty0", SEL_DUTY0, 191);
    wait_cyc(3060); checkOutput("sat_lo_duty0", SEL_DUTY0, 1);
    wait_cyc(3315); checkOutput("sat_lo_hold_duty0", SEL_DUTY0, 1);

    // Ramp again, then drop en[0] while pwm[0] is high.
    applyStimulus(2'b11, 2'b00, 255, 0, 100, 100);
    wait_cyc(3570); checkOutput("reramp_duty0", SEL_DUTY0, 65);
                    checkOutput("indep_duty1", SEL_DUTY1, 128);
    wait_cyc(3575); checkOutput("pre_drop_pwm0", SEL_PWM0, 1);
    applyStimulus(2'b10, 2'b00, 255, 0, 100, 100);
    wait_cyc(3576); checkOutput("drop_pwm0", SEL_PWM0, 0);
                    checkOutput("drop_duty0", SEL_DUTY0, 0);
                    checkOutput("drop_at0", SEL_AT0, 0);
                    checkOutput("drop_pwm1", SEL_PWM1, 1);
                    checkOutput("drop_duty1", SEL_DUTY1, 128);
                    checkOutput("drop_at1", SEL_AT1, 1);
    wait_cyc(3577);
    applyStimulus(2'b11, 2'b00, 255, 0, 100, 100);
    wait_cyc(3825); checkOutput("reen_duty0", SEL_DUTY0, 62);

    // One-cycle reset mid-ramp with enables held.
    wait_cyc(3830);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_duty0", SEL_DUTY0, 0);
    checkOutput("mid_rst_duty1", SEL_DUTY1, 0);
    checkOutput("mid_rst_pwm0",  SEL_PWM0,  0);
    checkOutput("mid_rst_pwm1",  SEL_PWM1,  0);
    checkOutput("mid_rst_at1",   SEL_AT1,   0);
    checkOutput("mid_rst_tick",  SEL_TICK,  0);
    rst = 1'b0;
    wait_cyc(1);   checkOutput("rel_tick_c1", SEL_TICK, 0);
    wait_cyc(2);   checkOutput("rel_tick_c2", SEL_TICK, 0);
    wait_cyc(3);   checkOutput("rel_tick_c3", SEL_TICK, 1);
    wait_cyc(4);   checkOutput("rel_tick_c4", SEL_TICK, 0);
    wait_cyc(8);   checkOutput("rel_at1", SEL_AT1, 1);
    wait_cyc(255); checkOutput("rel_duty0", SEL_DUTY0, 63);
                   checkOutput("rel_duty1", SEL_DUTY1, 1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
